// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - seven-segment display bus reader with settle filter and digit handshake
//
// Purpose: samples an asynchronous active-low 7-segment bus, waits for it to
// hold steady, decodes the accepted pattern to a hex digit and offers it to a
// consumer through a valid/ready handshake.
//
// Ports:
//   clk_i      in   1  clock, all logic on the rising edge
//   rst_i      in   1  synchronous active-high reset
//   seg_i      in   7  active-low segment bus, bit0=a .. bit6=g (asynchronous)
//   ready_i    in   1  consumer takes bcd_o when high together with valid_o
//   bcd_o      out  4  last decoded hex digit
//   valid_o    out  1  new digit pending, held until taken
//   blank_o    out  1  accepted pattern is all segments off
//   err_o      out  1  one-cycle pulse when an undecodable pattern is accepted
//   overrun_o  out  1  sticky, a pending digit was overwritten
//   err_cnt_o  out  8  saturating count of err_o pulses (SEG7_READER_ERR_CNT_EN only)
//
// Build option: define SEG7_READER_ERR_CNT_EN to add err_cnt_o.

module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] seg_i,
  input  logic       ready_i,
  output logic [3:0] bcd_o,
  output logic       valid_o,
  output logic       blank_o,
  output logic       err_o,
  output logic       overrun_o
`ifdef SEG7_READER_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt_o
`endif
);

  localparam logic [7:0] LP_CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] LP_CNT_ACC = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] LP_BLANK   = 7'h7F;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_STABLE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [6:0] r_prev;
  logic [6:0] r_last;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;

  logic [3:0] r_bcd;
  logic       r_valid;
  logic       r_blank;
  logic       r_err;
  logic       r_ovr;

  logic       w_changed;
  logic       w_accept;
  logic       w_new;
  logic       w_is_blank;
  logic       w_blank_ev;
  logic       w_digit_ev;
  logic       w_err_ev;
  logic       w_hit;
  logic [3:0] w_digit;
  logic [6:0] w_segs;

  assign w_changed = (r_sync2 != r_prev);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed) begin
      w_cnt_next = 8'd0;
    end else if (r_cnt != LP_CNT_MAX) begin
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  // For STABLE_CYCLES >= 2 the count can only reach the accept value while
  // the sample is unchanged. With STABLE_CYCLES == 1 the change cycle itself
  // is the accept cycle, so a change also qualifies out of STABLE.
  assign w_accept   = (w_cnt_next == LP_CNT_ACC) && ((r_state == ST_SETTLE) || w_changed);
  assign w_new      = w_accept && (r_sync2 != r_last);
  assign w_is_blank = (r_sync2 == LP_BLANK);
  assign w_blank_ev = w_new && w_is_blank;
  assign w_digit_ev = w_new && !w_is_blank && w_hit;
  assign w_err_ev   = w_new && !w_is_blank && !w_hit;

  // Decode table is written active-high (gfedcba).
  assign w_segs = ~r_sync2;

  always_comb begin
    w_hit   = 1'b1;
    w_digit = 4'h0;
    case (w_segs)
      7'b0111111: w_digit = 4'h0;
      7'b0000110: w_digit = 4'h1;
      7'b1011011: w_digit = 4'h2;
      7'b1001111: w_digit = 4'h3;
      7'b1100110: w_digit = 4'h4;
      7'b1101101: w_digit = 4'h5;
      7'b1111101: w_digit = 4'h6;
      7'b0000111: w_digit = 4'h7;
      7'b1111111: w_digit = 4'h8;
      7'b1101111: w_digit = 4'h9;
      7'b1110111: w_digit = 4'hA;
      7'b1111100: w_digit = 4'hB;
      7'b0111001: w_digit = 4'hC;
      7'b1011110: w_digit = 4'hD;
      7'b1111001: w_digit = 4'hE;
      7'b1110001: w_digit = 4'hF;
      default:    w_hit   = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_SETTLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SETTLE: if (w_accept) w_state_next = ST_STABLE;
      ST_STABLE: begin
        if (w_accept) begin
          w_state_next = ST_STABLE;
        end else if (w_changed) begin
          w_state_next = ST_SETTLE;
        end
      end
      default:   w_state_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= LP_BLANK;
      r_sync2 <= LP_BLANK;
      r_prev  <= LP_BLANK;
      r_last  <= LP_BLANK;
      r_cnt   <= 8'd0;
      r_bcd   <= 4'h0;
      r_valid <= 1'b0;
      r_blank <= 1'b1;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= seg_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_ev;
      if (w_accept) begin
        r_last <= r_sync2;
      end
      // A new digit beats a simultaneous handshake; overrun only when the
      // pending digit was never taken.
      if (w_digit_ev) begin
        r_bcd   <= w_digit;
        r_valid <= 1'b1;
        if (r_valid && !ready_i) begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_blank_ev) begin
        r_blank <= 1'b1;
      end else if (w_digit_ev || w_err_ev) begin
        r_blank <= 1'b0;
      end
    end
  end

`ifdef SEG7_READER_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_ev && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign bcd_o     = r_bcd;
  assign valid_o   = r_valid;
  assign blank_o   = r_blank;
  assign err_o     = r_err;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - self-checking bench for seg7_reader with an output-event scoreboard

module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic       ready;
  logic [3:0] bcd;
  logic       valid;
  logic       blank;
  logic       err;
  logic       overrun;
`ifdef SEG7_READER_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  logic [7:0] snap;
  assign snap = {err, overrun, blank, valid, bcd};

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .seg_i     (seg),
    .ready_i   (ready),
    .bcd_o     (bcd),
    .valid_o   (valid),
    .blank_o   (blank),
    .err_o     (err),
    .overrun_o (overrun)
`ifdef SEG7_READER_ERR_CNT_EN
    ,
    .err_cnt_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         n_chg  = 0;
  logic       mon_en = 1'b0;
  logic [7:0] mon_prev = 8'h20;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mk(input logic e, input logic o, input logic b,
                                    input logic v, input logic [3:0] d);
    return {e, o, b, v, d};
  endfunction

  // Active-high gfedcba table, inverted onto the active-low bus.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t;
    case (d)
      0: t = 7'b0111111;   1: t = 7'b0000110;   2: t = 7'b1011011;   3: t = 7'b1001111;
      4: t = 7'b1100110;   5: t = 7'b1101101;   6: t = 7'b1111101;   7: t = 7'b0000111;
      8: t = 7'b1111111;   9: t = 7'b1101111;  10: t = 7'b1110111;  11: t = 7'b1111100;
      12: t = 7'b0111001; 13: t = 7'b1011110;  14: t = 7'b1111001;  default: t = 7'b1110001;
    endcase
    return ~t;
  endfunction

  task automatic expect_ev(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    tag_q.delete();
  endtask

  // Every change of the output bundle must match the next scoreboard entry.
  initial begin
    logic [7:0] e;
    string      t;
    forever begin
      @(negedge clk);
      if (mon_en && (snap !== mon_prev)) begin
        n_chg++;
        if (exp_q.size() == 0) begin
          check("no_change", snap, mon_prev);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check(t, snap, e);
        end
        mon_prev = snap;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst   = 1'b1;
    seg   = 7'h7F;
    ready = 1'b0;

    @(posedge clk); #1;
    check("reset_state", snap, 8'h20);
`ifdef SEG7_READER_ERR_CNT_EN
    check("reset_err_cnt", err_cnt, 0);
`endif

    // First digit and its latency: update on edge 6 after the new value
    @(negedge clk);
    mon_prev = 8'h20;
    mon_en   = 1'b1;
    rst      = 1'b0;
    seg      = seg_of(3);
    expect_ev("digit3", mk(0, 0, 0, 1, 4'h3));
    repeat (5) @(posedge clk);
    #1 check("lat_edge5_valid", valid, 0);
    @(posedge clk);
    #1 check("lat_edge6_valid", valid, 1);
    check("lat_edge6_bcd", bcd, 4'h3);
    check("lat_edge6_blank", blank, 0);
    wait_drain("digit3", 10);

    // New digit with the old one still pending
    @(negedge clk);
    seg = seg_of(14);
    expect_ev("overrun_E", mk(0, 1, 0, 1, 4'hE));
    wait_drain("overrun_E", 20);

    // Pattern that never holds long enough must produce nothing
    base = n_chg;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seg = (i % 2 == 0) ? seg_of(1) : seg_of(14);
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("toggle_quiet", n_chg - base, 0);

    // Undecodable pattern: single err pulse, digit untouched
    @(negedge clk);
    seg = 7'b1111110;
    expect_ev("err_rise", mk(1, 1, 0, 1, 4'hE));
    expect_ev("err_fall", mk(0, 1, 0, 1, 4'hE));
    n = 0;
    while (err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("err_seen", err, 1);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    wait_drain("err", 10);
`ifdef SEG7_READER_ERR_CNT_EN
    check("err_cnt_inc", err_cnt, 1);
`endif

    // Blank, then handshake clears valid on the following cycle
    @(negedge clk);
    seg = 7'h7F;
    expect_ev("blank", mk(0, 1, 1, 1, 4'hE));
    wait_drain("blank", 20);
    @(negedge clk);
    ready = 1'b1;
    expect_ev("handshake", mk(0, 1, 1, 0, 4'hE));
    @(posedge clk);
    #1 check("valid_clear", valid, 0);
    @(negedge clk);
    ready = 1'b0;
    wait_drain("handshake", 5);

    @(negedge clk);
    seg = seg_of(2);
    expect_ev("digit2", mk(0, 1, 0, 1, 4'h2));
    wait_drain("digit2", 20);

    // Reset mid-settle with a digit pending
    @(negedge clk);
    seg = seg_of(4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_ev("reset_mid", 8'h20);
    @(posedge clk);
    #1 check("reset_mid_state", snap, 8'h20);
`ifdef SEG7_READER_ERR_CNT_EN
    check("reset_mid_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    expect_ev("digit4_after_reset", mk(0, 0, 0, 1, 4'h4));
    wait_drain("digit4", 20);

    // New digit on the same edge as a handshake: digit wins, no overrun
    @(negedge clk);
    seg = seg_of(9);
    expect_ev("coincide_load", mk(0, 0, 0, 1, 4'h9));
    expect_ev("coincide_take", mk(0, 0, 0, 0, 4'h9));
    repeat (5) @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1 check("coincide_valid", valid, 1);
    check("coincide_ovr", overrun, 0);
    @(posedge clk);
    #1 check("coincide_cleared", valid, 0);
    wait_drain("coincide", 10);

    // Whole decode table, consumer always ready
    for (int d = 0; d < 16; d++) begin
      @(negedge clk);
      seg = seg_of(d);
      expect_ev($sformatf("table_%0d_load", d), mk(0, 0, 0, 1, 4'(d)));
      expect_ev($sformatf("table_%0d_take", d), mk(0, 0, 0, 0, 4'(d)));
      wait_drain($sformatf("table_%0d", d), 20);
    end
    ready = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical synchronized samples required before a pattern is accepted.
REQ-002 The module SHALL have port clk_i, input, 1 bit: single clock; all logic rising-edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port seg_i, input, 7 bits: active-low segment bus, bit0=a … bit6=g; asynchronous to clk_i.
REQ-005 The module SHALL have port ready_i, input, 1 bit: consumer accepts bcd_o when high with valid_o.
REQ-006 The module SHALL have port bcd_o, output, 4 bits: last decoded hex digit 0x0..0xF.
REQ-007 The module SHALL have port valid_o, output, 1 bit: new digit pending; held until handshake.
REQ-008 The module SHALL have port blank_o, output, 1 bit: level; accepted pattern is all segments off.
REQ-009 The module SHALL have port err_o, output, 1 bit: one-cycle pulse on acceptance of a non-table, non-blank pattern.
REQ-010 The module SHALL have port overrun_o, output, 1 bit: sticky; a digit was overwritten while valid_o was high.

Function
REQ-011 seg_i SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The settle counter SHALL clear whenever the synchronized sample differs from the previous sample, and SHALL increment otherwise, saturating at STABLE_CYCLES.
REQ-013 A pattern SHALL be accepted on the cycle the counter reaches STABLE_CYCLES-1 with the sample unchanged; with seg_i constant, the output update occurs STABLE_CYCLES+2 rising edges after the first edge sampling the new value.
REQ-014 An accepted pattern equal to the previously accepted pattern SHALL produce no event.
REQ-015 The decode table (active-high gfedcba) SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-016 A new table pattern SHALL load bcd_o, set valid_o=1, and clear blank_o.
REQ-017 A new all-off pattern (seg_i=7'h7F) SHALL set blank_o=1 and leave bcd_o and valid_o unchanged.
REQ-018 A new invalid pattern SHALL pulse err_o for exactly one cycle, clear blank_o, and leave bcd_o and valid_o unchanged.
REQ-019 valid_o SHALL clear on the cycle after valid_o&&ready_i, unless a new digit event occurs in that same cycle.
REQ-020 When a digit event occurs while valid_o=1 and ready_i=0, the event SHALL overwrite bcd_o, keep valid_o=1, and set overrun_o.
REQ-021 When a digit event coincides with a handshake, the new digit SHALL win, valid_o SHALL stay 1, and overrun_o SHALL be unaffected.
REQ-022 The state machine SHALL have states SETTLE (counting), STABLE (accepted, waiting for change) and SETTLE re-entry on any sample change; no other states.

Reset
REQ-023 rst_i SHALL, at the next rising edge, clear synchronizer and previous-sample flops to 7'h7F, counter to 0, state to SETTLE, last-accepted pattern to 7'h7F, bcd_o=0, valid_o=0, blank_o=1, err_o=0, overrun_o=0.
REQ-024 rst_i asserted mid-settle or with valid_o pending SHALL discard all pending state; no event SHALL fire in the cycle reset is high.

Configuration
REQ-025 With macro SEG7_READER_ERR_CNT_EN defined, port err_cnt_o (output, 8 bits) SHALL exist, count err_o pulses, saturate at 255, and reset to 0.
REQ-026 Without SEG7_READER_ERR_CNT_EN, port err_cnt_o and its counter SHALL be absent; all other behaviour is identical.

Verification (STABLE_CYCLES=4)
REQ-027 After reset, drive seg_i=~7'b1001111 constant -> valid_o=1, bcd_o=4'h3 on edge 6; blank_o=0.
REQ-028 Hold ready_i=0, then drive a stable ~7'b1111001 pattern -> bcd_o=4'hE, valid_o stays 1, overrun_o=1.
REQ-029 Toggle seg_i every 3 cycles between two patterns -> no valid_o, err_o or blank_o change.
REQ-030 Drive stable seg_i=~7'b0000001 -> a single one-cycle err_o pulse, bcd_o unchanged, err_cnt_o increments by 1 when the macro is defined.
REQ-031 Drive seg_i=7'h7F after a digit -> blank_o=1, valid_o unchanged; with ready_i=1, valid_o clears one cycle after the handshake.
REQ-032 Assert rst_i for 1 cycle with valid_o=1 and a settle in progress -> all outputs equal the REQ-023 reset values on the next edge.
